mod_reduce_seq: RTL and testbench
=================================

// Module: mod_reduce_seq
// PURPOSE
//  Sequential modular reducer, directly downstream of the 264x256 sequential multiplier.
//  Takes its 520-bit product and returns product mod P (256-bit field prime, default secp256k1).
//  Method: pseudo-Mersenne folding, x = hi*2^256 + lo == hi*FOLD_C + lo (mod P),
//  then one conditional subtract of P.
//  Output feeds the ECC point add/double datapath as a fully reduced field element.
// PARAMETERS
//  P       256'hFFFF...FFFE_FFFF_FC2F (secp256k1)  field prime; must satisfy 2^255 < P < 2^256
//  FOLD_W  64                                      width of FOLD_C; must be <= 64
//  FOLD_C  64'h0000_0001_0000_03D1                 fold constant, 2^256 - P; must fit in FOLD_W bits
// PORTS
//  clk      in   1    clock, rising edge
//  rst      in   1    synchronous, active-high reset
//  start    in   1    level request; wire from multiplier valid
//  product  in   520  unreduced operand; sampled only in IDLE when start=1
//  busy     out  1    1 in FOLD/SUB
//  valid    out  1    result valid; held while in DONE
//  result   out  256  product mod P; stable while valid=1
// BEHAVIOUR
//  Reset, and any time rst=1 including mid-operation:
//   - state=IDLE; valid=0; busy=0; result=0; acc=0.
//   - Any in-flight reduction is discarded.
//  acc is a 520-bit internal register. hi=acc[519:256], lo=acc[255:0].
//  IDLE:
//   - valid<=0.
//   - If start=1: acc<=product; busy<=1; go to FOLD.
//  FOLD, one fold per cycle:
//   - hi!=0: acc <= lo + hi*FOLD_C. The product is FOLD_W+264 bits, zero-extended to 520.
//   - hi==0: go to SUB; acc unchanged.
//   - At most 3 folds for any 520-bit input with FOLD_W<=64, giving <=4 FOLD cycles.
//  SUB:
//   - acc>=P: acc<=acc-P; stay in SUB. At most once, because acc<2^256<2P.
//   - acc<P: result<=acc[255:0]; valid<=1; busy<=0; go to DONE.
//  DONE:
//   - valid stays 1 and result is held.
//   - When start=0: go to IDLE, and valid clears on that edge.
//   - start held high never retriggers; exactly one result per start pulse.
//  Latency:
//   - Rising edges from start sampled in IDLE to valid=1: 1 (load) + <=4 FOLD + <=2 SUB.
//   - Bound is <=7 edges. Data-dependent; the bench checks the bound, not an exact count.
//  Width rules:
//   - All adds are unsigned and carry-preserving in 520-bit acc; no truncation before SUB.
//   - The compare acc>=P is 520-bit unsigned.
//  Boundaries:
//   - product=0 reaches DONE with result=0.
//   - product in [P, 2^256) takes 0 folds and 1 subtract.
//   - product<P with hi=0 passes straight through.
//  Invariant: result<P whenever valid=1. The bench asserts this every cycle.
//  product may change after the load cycle without effect.
// STRUCTURE
//  Shared package ecc_pkg:
//   - FIELD_W=256, PROD_W=520.
//   - P_SECP256K1 and FOLD_C_SECP256K1 constants.
//   - State enum {IDLE, FOLD, SUB, DONE}, 2 bits, encoded 0..3.
//  One natural sub-module, mod_fold_step (combinational):
//   - in acc[519:0] -> out lo + hi*FOLD_C, plus flag hi_zero.
//   - Isolates the 264xFOLD_W multiplier for later pipelining or splitting into 24x16 tiles.
//  Top level holds the FSM, acc, the subtract/compare and the output registers.
// TESTING
//  1. product=0, start=1 -> valid=1 within 7 edges, result=0; busy=0 at valid.
//  2. product=P -> result=0. product=P+5 -> result=5. Each takes 0 folds and 1 subtract.
//  3. product=2^256 -> result=0x1_0000_03D1 (FOLD_C). product=(P-1)^2 -> result=1.
//  4. 2000 random products including 2^520-1 vs golden model (product % P):
//     - result matches;
//     - result<P at every valid;
//     - latency <=7.
//  5. start held high 20 cycles past valid -> one result only.
//     - Drop start -> IDLE, valid=0 next edge.
//     - Re-raise with a new product -> new correct result.
//  6. rst=1 on the 2nd FOLD cycle -> next edge: valid=0, busy=0, result=0, state IDLE.
//     - Then start with product=P+5 -> result=5.

Source files
------------

// File: rtl/ecc_pkg.sv
// ecc_pkg: shared widths, secp256k1 field constants and the reducer state
// encoding used across the ECC datapath.
//   FIELD_W          width of a fully reduced field element
//   PROD_W           width of the multiplier product fed to the reducer
//   P_SECP256K1      secp256k1 field prime
//   FOLD_C_SECP256K1 2^256 - P_SECP256K1, the pseudo-Mersenne fold constant
//   state_t          reducer FSM states
package ecc_pkg;

    localparam int FIELD_W = 256;
    localparam int PROD_W  = 520;

    localparam logic [FIELD_W-1:0] P_SECP256K1 =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

    localparam logic [63:0] FOLD_C_SECP256K1 = 64'h0000_0001_0000_03D1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FOLD = 2'd1,
        SUB  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mod_reduce_seq_if.sv
// mod_reduce_seq_if: request/response bundle between the multiplier side
// (master) and the modular reducer (slave).
//   start    master->slave  level request, sampled while the reducer is idle
//   product  master->slave  520-bit unreduced operand
//   busy     slave->master  reduction in progress
//   valid    slave->master  result valid, held until start drops
//   result   slave->master  product mod P
interface mod_reduce_seq_if;
    import ecc_pkg::*;

    logic               start;
    logic [PROD_W-1:0]  product;
    logic               busy;
    logic               valid;
    logic [FIELD_W-1:0] result;

    modport master (
        output start,
        output product,
        input  busy,
        input  valid,
        input  result
    );

    modport slave (
        input  start,
        input  product,
        output busy,
        output valid,
        output result
    );

endinterface

// File: rtl/mod_fold_step.sv
// mod_fold_step: one pseudo-Mersenne fold, purely combinational.
//   acc      in   520  value to fold, hi = acc[519:256], lo = acc[255:0]
//   folded   out  520  lo + hi*FOLD_C, zero-extended
//   hi_zero  out  1    hi == 0, no further fold is needed
// The 264 x FOLD_W multiply lives here alone so it can later be pipelined
// or split into smaller tiles without touching the control FSM.
module mod_fold_step
    import ecc_pkg::*;
#(
    parameter int                FOLD_W = 64,
    parameter logic [FOLD_W-1:0] FOLD_C = FOLD_C_SECP256K1[FOLD_W-1:0]
) (
    input  logic [PROD_W-1:0] acc,
    output logic [PROD_W-1:0] folded,
    output logic              hi_zero
);

    localparam int HI_W  = PROD_W - FIELD_W;  // 264
    localparam int MUL_W = HI_W + FOLD_W;     // full product width

    logic [HI_W-1:0]    hi;
    logic [FIELD_W-1:0] lo;
    logic [MUL_W-1:0]   hi_times_c;

    assign hi = acc[PROD_W-1:FIELD_W];
    assign lo = acc[FIELD_W-1:0];

    // Both operands are widened to the full product width so nothing is
    // truncated before the add.
    assign hi_times_c = {{FOLD_W{1'b0}}, hi} * {{HI_W{1'b0}}, FOLD_C};

    // hi*FOLD_C + lo is at most MUL_W+1 bits, well inside the 520-bit acc.
    assign folded  = {{(PROD_W-MUL_W){1'b0}}, hi_times_c} + {{HI_W{1'b0}}, lo};
    assign hi_zero = (hi == '0);

endmodule

// File: rtl/mod_reduce_seq.sv
// mod_reduce_seq: sequential reduction of a 520-bit product modulo a 256-bit
// pseudo-Mersenne prime P. Folds x = hi*2^256 + lo into lo + hi*FOLD_C until
// hi is zero, then subtracts P at most once.
//   clk   in   1    clock, rising edge
//   rst   in   1    synchronous, active-high reset
//   bus   slave      start/product in, busy/valid/result out
// One result is produced per start request; start must drop before the
// reducer accepts the next operand.
module mod_reduce_seq
    import ecc_pkg::*;
#(
    parameter logic [FIELD_W-1:0] P      = P_SECP256K1,
    parameter int                 FOLD_W = 64,
    parameter logic [FOLD_W-1:0]  FOLD_C = FOLD_C_SECP256K1[FOLD_W-1:0]
) (
    input  logic           clk,
    input  logic           rst,
    mod_reduce_seq_if.slave bus
);

    localparam logic [PROD_W-1:0] P_EXT = {{(PROD_W-FIELD_W){1'b0}}, P};

    state_t             state;
    logic [PROD_W-1:0]  acc;
    logic [PROD_W-1:0]  folded;
    logic               hi_zero;
    logic               busy_q;
    logic               valid_q;
    logic [FIELD_W-1:0] result_q;

    mod_fold_step #(
        .FOLD_W (FOLD_W),
        .FOLD_C (FOLD_C)
    ) u_fold (
        .acc     (acc),
        .folded  (folded),
        .hi_zero (hi_zero)
    );

    // NOTE: all state below updates with non-blocking assignments so every
    // branch reads the pre-edge values of state and acc.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    valid_q <= 1'b0;
                    if (bus.start) begin
                        acc    <= bus.product;
                        busy_q <= 1'b1;
                        state  <= FOLD;
                    end
                end

                FOLD: begin
                    if (hi_zero) begin
                        state <= SUB;
                    end else begin
                        acc <= folded;
                    end
                end

                SUB: begin
                    // acc < 2^256 < 2P here, so this subtract fires at most once.
                    if (acc >= P_EXT) begin
                        acc <= acc - P_EXT;
                    end else begin
                        result_q <= acc[FIELD_W-1:0];
                        valid_q  <= 1'b1;
                        busy_q   <= 1'b0;
                        state    <= DONE;
                    end
                end

                DONE: begin
                    // Holding start high must not retrigger; wait for it to drop.
                    if (!bus.start) begin
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.valid  = valid_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_mod_reduce_seq.sv
module tb_mod_reduce_seq;
    import ecc_pkg::*;

    localparam int MAX_LAT = 7;
    localparam int BUDGET  = 20;

    logic clk;
    logic rst;

    mod_reduce_seq_if bus ();

    mod_reduce_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    logic [FIELD_W-1:0] exp_q[$];
    logic               prev_valid = 1'b0;

    task automatic check(input string name, input logic [PROD_W-1:0] act,
                         input logic [PROD_W-1:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // Golden model: plain modular arithmetic on the whole product.
    function automatic logic [FIELD_W-1:0] model(input logic [PROD_W-1:0] x);
        logic [PROD_W-1:0] r;
        r = x % {{(PROD_W-FIELD_W){1'b0}}, P_SECP256K1};
        return r[FIELD_W-1:0];
    endfunction

    function automatic logic [PROD_W-1:0] rand_wide();
        logic [PROD_W-1:0] x;
        x = '0;
        for (int i = 0; i < 17; i++) x = {x[PROD_W-33:0], 32'($urandom())};
        return x;
    endfunction

    function automatic logic [PROD_W-1:0] rand_prod();
        logic [PROD_W-1:0] x;
        logic [PROD_W-1:0] p_ext;
        int                mode;
        x     = rand_wide();
        p_ext = {{(PROD_W-FIELD_W){1'b0}}, P_SECP256K1};
        mode  = int'($urandom_range(0, 5));
        case (mode)
            1: x[PROD_W-1:FIELD_W] = '0;                          // hi = 0
            2: x[PROD_W-1:FIELD_W+8] = '0;                        // tiny hi
            3: x = p_ext + PROD_W'($urandom_range(0, 16)) - PROD_W'(8); // near P
            4: x[PROD_W-1:PROD_W-64] = '1;                        // top heavy
            5: x[PROD_W-1:320] = '0;                              // mid size
            default: ;
        endcase
        return x;
    endfunction

    // Monitor: pops the scoreboard on every new valid and checks the range
    // invariant on every cycle that valid is high.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (bus.valid) begin
                check("result_lt_p", PROD_W'(bus.result < P_SECP256K1), PROD_W'(1));
                if (!prev_valid) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL unexpected_result: got %h, expected no result", bus.result);
                    end else begin
                        check("scoreboard", PROD_W'(bus.result), PROD_W'(exp_q.pop_front()));
                    end
                end
            end
            prev_valid = bus.valid;
        end
    end

    // One full request: load, wait for valid with a bounded budget, optionally
    // hold start for `hold` extra cycles, then drop start and check the clear.
    task automatic do_op(input logic [PROD_W-1:0] p, input logic [FIELD_W-1:0] expv,
                         input int hold);
        int edges;
        edges = 0;
        exp_q.push_back(expv);
        @(negedge clk);
        bus.product = p;
        bus.start   = 1'b1;
        while (edges < BUDGET) begin
            @(posedge clk);
            edges++;
            #1;
            if (edges == 1) bus.product = rand_wide();  // must be ignored after load
            if (bus.valid) break;
        end
        check("latency_le_7", PROD_W'(edges <= MAX_LAT && bus.valid), PROD_W'(1));
        check("busy_at_valid", PROD_W'(bus.busy), PROD_W'(0));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", PROD_W'(bus.valid), PROD_W'(1));
            check("hold_result", PROD_W'(bus.result), PROD_W'(expv));
        end
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check("valid_clear", PROD_W'(bus.valid), PROD_W'(0));
    endtask

    initial begin
        logic [PROD_W-1:0] p_ext;
        logic [PROD_W-1:0] pm1;
        logic [PROD_W-1:0] x;

        p_ext = {{(PROD_W-FIELD_W){1'b0}}, P_SECP256K1};
        pm1   = p_ext - PROD_W'(1);

        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.product = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", PROD_W'(bus.valid), PROD_W'(0));
        check("rst_busy", PROD_W'(bus.busy), PROD_W'(0));
        check("rst_result", PROD_W'(bus.result), PROD_W'(0));
        @(negedge clk);
        rst = 1'b0;

        // Directed boundaries with spec-given answers.
        do_op('0, '0, 0);
        do_op(p_ext, '0, 0);
        do_op(p_ext + PROD_W'(5), 256'd5, 0);
        x = '0;
        x[256] = 1'b1;
        do_op(x, 256'h1_0000_03D1, 0);
        do_op(pm1 * pm1, 256'd1, 0);
        do_op('1, model('1), 0);

        // Start held high past valid, then a fresh request.
        x = rand_wide();
        do_op(x, model(x), 20);
        x = rand_wide();
        do_op(x, model(x), 0);

        // Randomized products against the golden model.
        for (int n = 0; n < 2000; n++) begin
            x = rand_prod();
            do_op(x, model(x), 0);
        end

        // Reset during the second FOLD cycle discards the operation.
        @(negedge clk);
        bus.product = '1;
        bus.start   = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst       = 1'b1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_valid", PROD_W'(bus.valid), PROD_W'(0));
        check("midrst_busy", PROD_W'(bus.busy), PROD_W'(0));
        check("midrst_result", PROD_W'(bus.result), PROD_W'(0));
        check("midrst_state", PROD_W'(dut.state), PROD_W'(IDLE));
        @(negedge clk);
        rst = 1'b0;
        do_op(p_ext + PROD_W'(5), 256'd5, 0);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", PROD_W'(exp_q.size()), PROD_W'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
